apb_bridge_ctrl: RTL

APB_BRIDGE_CTRL -- requirements
Module: apb_bridge_ctrl

---
 rtl/apb_bridge_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/apb_bridge_ctrl.sv
// AHB-to-APB bridge controller.
// Accepts single AHB transfers in IDLE or ENABLE, decodes the address into
// one of three APB slave selects and runs the APB SETUP/ENABLE handshake.
// Writes take one extra wait state (WWAIT) so that Hwdata, valid in the AHB
// data phase, can be captured before the APB setup phase. Bad transfers get
// a two-cycle AHB ERROR response without touching the APB side.
module apb_bridge_ctrl (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic        Hreadyin,
  input  logic [31:0] Haddr,
  input  logic        Hwrite,
  input  logic [31:0] Hwdata,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Hreadyout,
  input  logic [31:0] Prdata,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Pwrite,
  output logic [2:0]  Pselx,
  output logic        Penable
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WWAIT  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ENABLE = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  // Map an address onto the one-hot APB select; 000 means unmapped.
  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    case (addr[31:26])
      6'b100000: sel = 3'b001;  // 0x8000_0000 - 0x83FF_FFFF
      6'b100001: sel = 3'b010;  // 0x8400_0000 - 0x87FF_FFFF
      6'b100010: sel = 3'b100;  // 0x8800_0000 - 0x8BFF_FFFF
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

  // Only byte, halfword and word transfers fit the 32-bit APB side.
  function automatic logic size_ok(input logic [2:0] size);
    return (size <= 3'd2);
  endfunction

  logic [2:0]  state_q,     state_d;
  logic [2:0]  sel_q,       sel_d;
  logic [31:0] paddr_q,     paddr_d;
  logic [31:0] pwdata_q,    pwdata_d;
  logic        pwrite_q,    pwrite_d;
  logic [2:0]  pselx_q,     pselx_d;
  logic        penable_q,   penable_d;
  logic        hreadyout_q, hreadyout_d;
  logic [1:0]  hresp_q,     hresp_d;

  logic        accept_state_s;
  logic        sample_s;
  logic [2:0]  dec_sel_s;
  logic        good_s;

  // Qualify the AHB address phase and classify it as good or bad.
  always_comb begin
    accept_state_s = (state_q == ST_IDLE) || (state_q == ST_ENABLE);
    sample_s       = Hreadyin && ((Htrans == 2'b10) || (Htrans == 2'b11)) && accept_state_s;
    dec_sel_s      = decode_sel(Haddr);
    good_s         = (dec_sel_s != 3'b000) && size_ok(Hsize);
  end

  // Bridge state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_ENABLE: begin
        if (sample_s) begin
          if (good_s) begin
            state_d = Hwrite ? ST_WWAIT : ST_SETUP;
          end else begin
            state_d = ST_ERR1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WWAIT:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ENABLE;
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Address/direction/select capture on a good sample, write data on WWAIT exit.
  always_comb begin
    sel_d    = sel_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    if (sample_s && good_s) begin
      sel_d    = dec_sel_s;
      paddr_d  = Haddr;
      pwrite_d = Hwrite;
    end else begin
      sel_d    = sel_q;
      paddr_d  = paddr_q;
      pwrite_d = pwrite_q;
    end
    if (state_q == ST_WWAIT) begin
      pwdata_d = Hwdata;
    end else begin
      pwdata_d = pwdata_q;
    end
  end

  // Output values for the state being entered, so the outputs come from flops.
  always_comb begin
    pselx_d     = 3'b000;
    penable_d   = 1'b0;
    hreadyout_d = 1'b1;
    hresp_d     = RESP_OKAY;
    case (state_d)
      ST_IDLE: begin
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
      end
      ST_WWAIT: begin
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        hresp_d     = RESP_OKAY;
      end
      ST_SETUP: begin
        pselx_d     = sel_d;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        hresp_d     = RESP_OKAY;
      end
      ST_ENABLE: begin
        pselx_d     = sel_d;
        penable_d   = 1'b1;
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
      end
      ST_ERR1: begin
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b0;
        hresp_d     = RESP_ERROR;
      end
      ST_ERR2: begin
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = RESP_ERROR;
      end
      default: begin
        pselx_d     = 3'b000;
        penable_d   = 1'b0;
        hreadyout_d = 1'b1;
        hresp_d     = RESP_OKAY;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge Hclk or posedge Hreset) begin
    if (Hreset) begin
      state_q     <= ST_IDLE;
      sel_q       <= 3'b000;
      paddr_q     <= 32'h0000_0000;
      pwdata_q    <= 32'h0000_0000;
      pwrite_q    <= 1'b0;
      pselx_q     <= 3'b000;
      penable_q   <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= RESP_OKAY;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pwrite_q    <= pwrite_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  assign Paddr     = paddr_q;
  assign Pwdata    = pwdata_q;
  assign Pwrite    = pwrite_q;
  assign Pselx     = pselx_q;
  assign Penable   = penable_q;
  assign Hreadyout = hreadyout_q;
  assign Hresp     = hresp_q;
  // Read data passes straight through; it is meaningful in ENABLE of a read.
  assign Hrdata    = Prdata;

endmodule
